ram_arb2: RTL and testbench
===========================

Name: ram_arb2

Overview:
- Two-requester arbiter/controller for the team's single-port synchronous-write, asynchronous-read 128x32 RAM.
- Sits between two client engines and one RAM instance. Each client uses a valid/ready request channel and a 1-cycle response channel.
- Arbitration is fair round-robin.
- The block drives the RAM's clk-domain write enable, address and data, and samples the RAM's combinational read data.

Parameters:
Data_width, 32, bits per RAM word
Addr_width, 7, RAM address bits (depth 2**Addr_width)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
p0_valid  input  1  port 0 request valid
p0_we  input  1  port 0 request is write (1) / read (0)
p0_address  input  Addr_width  port 0 word address
p0_d  input  Data_width  port 0 write data
p0_ready  output  1  port 0 request accepted this cycle
p0_rsp_valid  output  1  port 0 response pulse
p0_rsp_q  output  Data_width  port 0 response data
p1_valid / p1_we / p1_address / p1_d / p1_ready / p1_rsp_valid / p1_rsp_q  same as port 0, for port 1
ram_we  output  1  RAM write enable
ram_address  output  Addr_width  RAM address
ram_d  output  Data_width  RAM write data
ram_q  input  Data_width  RAM combinational read data
busy  output  1  high while the block is not accepting requests (init sweep)

Behaviour:
- Reset:
  - State goes to INIT if RAM_CLEAR_EN is defined, otherwise RUN.
  - rr_ptr=0 (port 0 favoured).
  - All rsp_valid=0, rsp_q=0.
  - ready outputs=0 while reset is high.
- Arbitration (RUN, combinational):
  - Only one port valid: that port is granted.
  - Both ports valid: the port equal to rr_ptr is granted.
  - pN_ready = grant to port N. At most one ready per cycle.
- rr_ptr update: on any grant, rr_ptr <= index of the non-granted port. With no grant, rr_ptr holds.
- RAM drive:
  - ram_address/ram_d = granted port's address/data.
  - ram_we = grant & that port's we.
  - No grant: ram_we=0, ram_address=0, ram_d=0.
- Response timing:
  - On the grant cycle, ram_q is registered into the granted port's rsp_q, and its rsp_valid is set for exactly the next cycle. Latency is 1 cycle for both reads and writes.
  - Write response carries the pre-write contents (RAM reads old data during the write cycle).
  - rsp_q holds its value when rsp_valid=0.
- Client rules:
  - Request fields must stay stable while valid=1 and ready=0.
  - Clients cannot stall responses; there is no rsp_ready.
  - A port may be granted on back-to-back cycles only if the other port is not valid.
- States:
  - INIT: sweep counter 0..2**Addr_width-1, ram_we=1, ram_d=0. busy=1, readies=0. After the last address, go to RUN on the next cycle.
  - RUN: busy=0, normal arbitration.
- Boundary conditions:
  - Address wrap is not applicable; addresses pass through unchanged.
  - Reset asserted mid-operation: any pending response is dropped (rsp_valid=0 on the next edge), rr_ptr=0, and the sweep restarts from address 0.
  - Same address requested by both ports in one cycle: serialised by the arbiter. The loser observes the winner's write.

Optional Feature:
RAM_CLEAR_EN:
- Defined: INIT state exists. After every reset, 2**Addr_width zero-writes take place, busy is high for exactly 2**Addr_width cycles, then RUN.
- Undefined: no INIT state, no sweep counter. busy is tied 0, and RUN starts the first cycle after reset deasserts. RAM contents are undefined until written.

Decomposition:
- Shared package: state encoding (ST_INIT, ST_RUN), port index constants (PORT0=0, PORT1=1), default widths DATA_W=32, ADDR_W=7.
- One natural sub-module: rr_arb2 (2-way round-robin grant logic plus rr_ptr register; inputs req[1:0], outputs gnt[1:0]). Datapath mux and response registers stay in ram_arb2.

Test Plan:
- Reset with RAM_CLEAR_EN -> busy=1 for 128 cycles, ram_we=1 with addresses 0..127 and ram_d=0; then busy=0 and reading address 5 returns 0.
- p0 writes 0xDEADBEEF to address 10, then p0 reads address 10 -> write rsp_q = old value; read rsp_q=0xDEADBEEF one cycle after grant.
- p0 and p1 both valid continuously for 8 cycles -> grants alternate 0,1,0,1…; each rsp_valid pulses on alternate cycles.
- Only p1 valid for 3 cycles -> p1_ready=1 on every cycle; a subsequent simultaneous request is granted to port 0.
- Same cycle: p0 writes 0x11 and p1 reads address 3 (rr_ptr=0) -> p0 wins; p1 is granted next cycle and p1_rsp_q=0x11.
- Reset asserted the cycle after a grant -> no rsp_valid appears; rr_ptr=0; the sweep restarts at address 0.

Source files
------------

// File: rtl/ram_arb2_pkg.sv
// Shared definitions for the two-port round-robin RAM arbiter (ram_arb2).
// The optional power-up clear sweep is enabled with the RAM_CLEAR_EN macro.
package ram_arb2_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PORT0  = 0;
    localparam int PORT1  = 1;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;

endpackage

// File: rtl/ram_arb2_rr.sv
// rr_arb2: 2-way round-robin grant logic with its own priority pointer.
// The pointer names the port favoured on the next cycle both ports request.
module rr_arb2
    import ram_arb2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == 1'(PORT1)) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After any grant the other port becomes favoured; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'(PORT0);
        end else if (gnt != 2'b00) begin
            rr_ptr <= gnt[0] ? 1'(PORT1) : 1'(PORT0);
        end
    end

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: arbitrates two valid/ready clients onto one sync-write/async-read RAM.
// Define RAM_CLEAR_EN to zero the whole RAM after every reset before serving requests.
module ram_arb2
    import ram_arb2_pkg::*;
#(
    parameter int DATA_W = ram_arb2_pkg::DATA_W,
    parameter int ADDR_W = ram_arb2_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_d,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_q,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_d,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_q,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    logic              run;
    logic [1:0]        gnt;
    logic [1:0]        rsp_vld_p1;
    logic [DATA_W-1:0] rsp_q_p1 [2];

`ifdef RAM_CLEAR_EN
    state_t            state;
    logic [ADDR_W-1:0] sweep;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
        end else if (state == ST_INIT) begin
            sweep <= sweep + 1'b1;
            if (sweep == {ADDR_W{1'b1}}) begin
                state <= ST_RUN;
            end
        end
    end

    assign busy = (state == ST_INIT);
    assign run  = (state == ST_RUN);
`else
    assign busy = 1'b0;
    assign run  = 1'b1;
`endif

    // Readies are forced low while reset is held so nothing is accepted that would be lost.
    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (run & ~reset),
        .req   ({p1_valid, p0_valid}),
        .gnt   (gnt)
    );

    assign p0_ready = gnt[PORT0];
    assign p1_ready = gnt[PORT1];

    always_comb begin
        ram_we      = 1'b0;
        ram_address = '0;
        ram_d       = '0;
`ifdef RAM_CLEAR_EN
        if (state == ST_INIT) begin
            ram_we      = ~reset;
            ram_address = sweep;
        end
`endif
        if (gnt[PORT0]) begin
            ram_we      = p0_we;
            ram_address = p0_address;
            ram_d       = p0_d;
        end else if (gnt[PORT1]) begin
            ram_we      = p1_we;
            ram_address = p1_address;
            ram_d       = p1_d;
        end
    end

    // Stage p0 -> p1: capture the RAM read (old data on writes) for the granted port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_p1  <= 2'b00;
            rsp_q_p1[0] <= '0;
            rsp_q_p1[1] <= '0;
        end else begin
            rsp_vld_p1 <= gnt;
            if (gnt[PORT0]) rsp_q_p1[0] <= ram_q;
            if (gnt[PORT1]) rsp_q_p1[1] <= ram_q;
        end
    end

    assign p0_rsp_valid = rsp_vld_p1[PORT0];
    assign p1_rsp_valid = rsp_vld_p1[PORT1];
    assign p0_rsp_q     = rsp_q_p1[0];
    assign p1_rsp_q     = rsp_q_p1[1];

endmodule

// File: tb/tb_ram_arb2.sv
// Self-checking bench for ram_arb2: behavioural RAM/arbiter model plus directed literal checks.
// Works with or without RAM_CLEAR_EN defined.
module tb_ram_arb2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
    logic [6:0]  p0_address = 0, p1_address = 0;
    logic [31:0] p0_d = 0, p1_d = 0;
    logic        p0_ready, p0_rsp_valid, p1_ready, p1_rsp_valid;
    logic [31:0] p0_rsp_q, p1_rsp_q;
    logic        ram_we, busy;
    logic [6:0]  ram_address;
    logic [31:0] ram_d, ram_q;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ram_arb2 dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_address(p0_address), .p0_d(p0_d),
        .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_q(p0_rsp_q),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_address(p1_address), .p1_d(p1_d),
        .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_q(p1_rsp_q),
        .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q),
        .busy(busy)
    );

    // RAM instance stand-in: synchronous write, combinational read.
    logic [31:0] ram_mem [128];
    always @(posedge clk) if (ram_we) ram_mem[ram_address] <= ram_d;
    assign ram_q = ram_mem[ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_mem [128];
    bit          m_vld [2] = '{0, 0};
    logic [31:0] m_q   [2] = '{32'h0, 32'h0};
    int          m_fav = 0;
    bit          m_init = 0;
    int          m_sweep = 0;

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = 32'(i) * 32'h01010101;
            m_mem[i]   = 32'(i) * 32'h01010101;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        v  [2];
            logic        w  [2];
            logic [6:0]  a  [2];
            logic [31:0] d  [2];
            int          g;
            v = '{p0_valid, p1_valid};
            w = '{p0_we, p1_we};
            a = '{p0_address, p1_address};
            d = '{p0_d, p1_d};
            chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(m_vld[0]));
            chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(m_vld[1]));
            chk("p0_rsp_q", p0_rsp_q, m_q[0]);
            chk("p1_rsp_q", p1_rsp_q, m_q[1]);
            if (reset) begin
                chk("ready_in_reset", {p1_ready, p0_ready}, 32'd0);
                m_vld = '{0, 0};
                m_q   = '{32'h0, 32'h0};
                m_fav = 0;
`ifdef RAM_CLEAR_EN
                m_init  = 1;
                m_sweep = 0;
`endif
            end else if (m_init) begin
                chk("busy_init", 32'(busy), 32'd1);
                chk("ready_init", {p1_ready, p0_ready}, 32'd0);
                chk("sweep_we", 32'(ram_we), 32'd1);
                chk("sweep_addr", 32'(ram_address), 32'(m_sweep));
                chk("sweep_d", ram_d, 32'd0);
                m_mem[m_sweep] = 32'd0;
                m_vld = '{0, 0};
                if (m_sweep == 127) m_init = 0;
                else m_sweep++;
            end else begin
                g = -1;
                if (v[0] && v[1]) g = m_fav;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
                chk("busy_run", 32'(busy), 32'd0);
                chk("p0_ready", 32'(p0_ready), 32'(g == 0));
                chk("p1_ready", 32'(p1_ready), 32'(g == 1));
                m_vld = '{0, 0};
                if (g < 0) begin
                    chk("idle_we", 32'(ram_we), 32'd0);
                    chk("idle_addr", 32'(ram_address), 32'd0);
                    chk("idle_d", ram_d, 32'd0);
                end else begin
                    chk("ram_we", 32'(ram_we), 32'(w[g]));
                    chk("ram_addr", 32'(ram_address), 32'(a[g]));
                    chk("ram_d", ram_d, d[g]);
                    m_vld[g] = 1;
                    m_q[g]   = m_mem[a[g]];
                    if (w[g]) m_mem[a[g]] = d[g];
                    m_fav = 1 - g;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep(input string name);
        int cnt = 0;
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        chk(name, 32'(cnt), 32'd128);
`else
        @(negedge clk);
        chk(name, 32'(busy), 32'd0);
`endif
        step();
    endtask

    initial begin
        logic [7:0] seq;
        int         p1_cnt;
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq;
        int         p1_cnt;
        step();
        chk_en = 1;
        step();
        step();
        reset = 0;
        wait_sweep("busy_cycles_after_reset");

        // Read address 5
        p0_valid = 1; p0_we = 0; p0_address = 7'd5;
        step();
        p0_valid = 0;
        @(negedge clk);
`ifdef RAM_CLEAR_EN
        chk("lit_read5", p0_rsp_q, 32'h00000000);
`else
        chk("lit_read5", p0_rsp_q, 32'h05050505);
`endif
        step();

        // Write DEADBEEF to 10, then read it back
        p0_valid = 1; p0_we = 1; p0_address = 7'd10; p0_d = 32'hDEADBEEF;
        step();
        p0_we = 0; p0_d = 0;
        @(negedge clk);
`ifdef RAM_CLEAR_EN
        chk("lit_write_old", p0_rsp_q, 32'h00000000);
`else
        chk("lit_write_old", p0_rsp_q, 32'h0A0A0A0A);
`endif
        step();
        p0_valid = 0;
        @(negedge clk);
        chk("lit_read10", p0_rsp_q, 32'hDEADBEEF);
        chk("lit_read10_vld", 32'(p0_rsp_valid), 32'd1);
        step();

        // Only p1 valid for 3 cycles
        p1_cnt = 0;
        p1_valid = 1; p1_we = 0; p1_address = 7'd20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p1_ready) p1_cnt++;
            step();
        end
        chk("lit_p1_only_grants", 32'(p1_cnt), 32'd3);

        // Both valid for 8 cycles: alternate starting with port 0
        p0_valid = 1; p0_we = 0; p0_address = 7'd10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq[i] = p1_ready;
            step();
        end
        chk("lit_alternate", 32'(seq), 32'h000000AA);
        p0_valid = 0; p1_valid = 0;
        @(negedge clk);
        chk("lit_last_rsp_p1", 32'(p1_rsp_valid), 32'd1);
        step();

        // Same-address collision: p0 writes 0x11 to 3, p1 reads 3
        p0_valid = 1; p0_we = 1; p0_address = 7'd3; p0_d = 32'h11;
        p1_valid = 1; p1_we = 0; p1_address = 7'd3;
        @(negedge clk);
        chk("lit_collision_p0_wins", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 0; p0_we = 0; p0_d = 0;
        @(negedge clk);
        chk("lit_collision_p1_next", 32'(p1_ready), 32'd1);
        step();
        p1_valid = 0;
        @(negedge clk);
        chk("lit_collision_p1_q", p1_rsp_q, 32'h00000011);
        step();

        // Grant p0, then reset the following cycle
        p0_valid = 1; p0_address = 7'd0;
        step();
        p0_valid = 0;
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("lit_reset_drops_rsp", {p1_rsp_valid, p0_rsp_valid}, 32'd0);
`ifdef RAM_CLEAR_EN
        chk("lit_sweep_restart", 32'(ram_address), 32'd0);
`endif
        wait_sweep("busy_cycles_after_midreset");
        p0_valid = 1; p1_valid = 1; p0_address = 7'd1; p1_address = 7'd2;
        @(negedge clk);
        chk("lit_rr_reset_p0", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 0; p1_valid = 0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
